decoder_scan_sequencer: RTL and testbench

//   Upstream driver for the 4-to-16 one-hot decoder. Steps the decoder's

---
 rtl/decoder_scan_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// decoder_scan_sequencer
//   Drives the select and enable of a one-hot row decoder. It steps through
//   the enabled rows of a 2**SEL_W-row scan. The enable is held for DWELL
//   cycles on each row, and an optional BLANK-cycle gap follows each row.
//   Frames can be one-shot or continuous. Rows can be skipped through a live
//   mask, and a scan can be aborted immediately.
//
// Ports
//   clk         clock, rising-edge
//   rst         asynchronous active-high reset
//   start       level request to begin a frame (only acted on while idle)
//   stop        abort the scan; wins over start
//   continuous  1 = repeat frames, 0 = one frame (sampled at frame end)
//   row_mask    1 = visit row i; read at each row selection
//   binary      registered row select to the decoder
//   en          registered decoder enable
//   busy        registered, high while scanning (dwell or blank)
//   done        one-cycle pulse when a one-shot frame ends (or empty start)
//   frame_wrap  one-cycle pulse on the first cycle of a wrapped frame
// ---------------------------------------------------------------------------
module decoder_scan_sequencer #(
  parameter int SEL_W = 4,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [2**SEL_W-1:0]   row_mask,
  output logic [SEL_W-1:0]      binary,
  output logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_wrap
);

  localparam int N       = 2**SEL_W;
  localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  // BLANK = 0 never enters the gap state; the constant only has to be legal.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SEL_W-1:0]   binary_reg, binary_next;
  logic               en_reg, busy_reg, done_reg, wrap_reg;
  logic               done_next, wrap_next;

  // Row search over the live mask: lowest set row overall, and lowest set
  // row strictly above the current one. The descending loop leaves the
  // lowest match as the final assignment.
  logic               low_found, above_found;
  logic [SEL_W-1:0]   low_idx, above_idx;

  always_comb begin
    low_found   = 1'b0;
    low_idx     = '0;
    above_found = 1'b0;
    above_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (row_mask[i]) begin
        low_found = 1'b1;
        low_idx   = SEL_W'(i);
        if (i > int'(binary_reg)) begin
          above_found = 1'b1;
          above_idx   = SEL_W'(i);
        end
      end
    end
  end

  // Outcome of a row advance: next row up, wrap to the first row, or end
  // of frame.
  state_t             adv_state;
  logic [SEL_W-1:0]   adv_binary;
  logic               adv_done, adv_wrap;

  always_comb begin
    adv_state  = ST_IDLE;
    adv_binary = binary_reg;
    adv_done   = 1'b0;
    adv_wrap   = 1'b0;
    if (above_found) begin
      adv_state  = ST_ACTIVE;
      adv_binary = above_idx;
    end else if (continuous && low_found) begin
      adv_state  = ST_ACTIVE;
      adv_binary = low_idx;
      adv_wrap   = 1'b1;
    end else begin
      adv_done   = 1'b1;
    end
  end

  // Next-state logic. The counter restarts at every transition, including
  // an ACTIVE->ACTIVE re-dwell of the same row.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + CNT_W'(1);
    binary_next = binary_reg;
    done_next   = 1'b0;
    wrap_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (start && !stop) begin
          if (low_found) begin
            state_next  = ST_ACTIVE;
            binary_next = low_idx;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (stop) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DWELL_LAST) begin
          cnt_next = '0;
          if (BLANK > 0) begin
            state_next = ST_BLANK;
          end else begin
            state_next  = adv_state;
            binary_next = adv_binary;
            done_next   = adv_done;
            wrap_next   = adv_wrap;
          end
        end
      end
      ST_BLANK: begin
        if (stop) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == BLANK_LAST) begin
          cnt_next    = '0;
          state_next  = adv_state;
          binary_next = adv_binary;
          done_next   = adv_done;
          wrap_next   = adv_wrap;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      binary_reg <= '0;
      en_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      binary_reg <= binary_next;
      en_reg     <= (state_next == ST_ACTIVE);
      busy_reg   <= (state_next != ST_IDLE);
      done_reg   <= done_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign binary     = binary_reg;
  assign en         = en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign frame_wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_sequencer
//   Directed bench for decoder_scan_sequencer (SEL_W=4, DWELL=4, BLANK=1).
//   A row-timer model predicts every output cycle by cycle. Directed
//   scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

  localparam int SEL_W = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int N     = 16;
  localparam int ROW_T = DWELL + BLANK;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             continuous;
  logic [N-1:0]     row_mask;
  logic [SEL_W-1:0] binary;
  logic             en;
  logic             busy;
  logic             done;
  logic             frame_wrap;

  int errors = 0;
  int checks = 0;

  decoder_scan_sequencer #(
    .SEL_W(SEL_W),
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .row_mask   (row_mask),
    .binary     (binary),
    .en         (en),
    .busy       (busy),
    .done       (done),
    .frame_wrap (frame_wrap)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Model: a scan is "running on row r, t cycles into that row". The enable
  // is high for t < DWELL. Each row lasts DWELL+BLANK cycles.
  // -------------------------------------------------------------------------
  typedef struct packed {
    bit busy;
    int row;
    int t;
    bit done;
    bit wrap;
  } mstate_t;

  mstate_t m;

  // Returns the lowest set row above 'from', or -1 if there is none.
  function automatic int next_row(input logic [N-1:0] msk, input int from);
    for (int i = from + 1; i < N; i++)
      if (msk[i]) return i;
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t c);
    mstate_t n;
    n      = c;
    n.done = 1'b0;
    n.wrap = 1'b0;
    if (!c.busy) begin
      if (start && !stop) begin
        if (row_mask != '0) begin
          n.busy = 1'b1;
          n.row  = next_row(row_mask, -1);
          n.t    = 0;
        end else begin
          n.done = 1'b1;
        end
      end
    end else if (stop) begin
      n.busy = 1'b0;
      n.t    = 0;
    end else if (c.t == ROW_T - 1) begin
      n.t = 0;
      if (next_row(row_mask, c.row) >= 0) begin
        n.row = next_row(row_mask, c.row);
      end else if (continuous && row_mask != '0) begin
        n.row  = next_row(row_mask, -1);
        n.wrap = 1'b1;
      end else begin
        n.busy = 1'b0;
        n.done = 1'b1;
      end
    end else begin
      n.t = c.t + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= step(m);
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      logic [7:0] got, exp;
      got = {binary, en, busy, done, frame_wrap};
      exp = {4'(m.row), (m.busy && m.t < DWELL), m.busy, m.done, m.wrap};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cycle t=%0t got {bin,en,busy,done,wrap}=%h exp=%h",
                 $time, got, exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Raise start for one cycle. On return, the first row is being driven.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic abort_scan();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    row_mask   = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("reset_binary", binary, 0);
    check("reset_en", en, 0);
    check("reset_busy", busy, 0);
    check("reset_done_wrap", {done, frame_wrap}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn reset released");

    // Full one-shot frame. Cycle k counts from the first enabled cycle.
    pulse_start();
    for (int k = 0; k < 16 * ROW_T; k++) begin
      check("t2_row", binary, k / ROW_T);
      check("t2_en", en, ((k % ROW_T) < DWELL) ? 1 : 0);
      check("t2_busy_nodone", {busy, done}, 2'b10);
      @(negedge clk);
    end
    check("t2_done_at_80", {done, busy, en}, 3'b100);
    check("t2_binary_end", binary, 15);
    @(negedge clk);
    check("t2_done_one_cycle", done, 0);
    $display("txn full one-shot frame");

    // Reset asserted between edges while row 7 is lit.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (binary == 4'd7 && en) found = 1'b1;
      else @(negedge clk);
    end
    check("t1_reach_row7", found, 1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_binary", binary, 0);
    check("t1_async_en_busy", {en, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_idle_after", {en, busy}, 0);
    $display("txn async reset mid-row");

    // Stop during the second dwell cycle of row 5.
    pulse_start();
    repeat (5 * ROW_T + 1) @(negedge clk);
    check("t4_row5_dwell2", {binary, en}, {4'd5, 1'b1});
    abort_scan();
    check("t4_stop_en_busy", {en, busy}, 0);
    check("t4_stop_binary", binary, 5);
    check("t4_stop_nodone", done, 0);
    row_mask = 16'h0030;
    pulse_start();
    check("t4_restart_low", {binary, en}, {4'd4, 1'b1});
    abort_scan();
    $display("txn stop mid-dwell and restart");

    // Empty mask.
    row_mask = 16'h0000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_done_pulse", {done, busy, en}, 3'b100);
    @(negedge clk);
    check("t5_done_gone", {done, busy, en}, 0);
    $display("txn empty mask start");

    // Start while busy is ignored. Start with stop in IDLE stays idle.
    row_mask = 16'hFFFF;
    pulse_start();
    repeat (6) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("t6_start_ignored", {binary, en, busy}, {4'd1, 1'b0, 1'b1});
    abort_scan();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("t6_start_stop_idle", {busy, en, done}, 0);
    $display("txn start while busy, start+stop idle");

    // Clear mask bit 3 while row 2 is lit.
    row_mask = 16'h001C;
    pulse_start();
    check("t6_first_row2", binary, 2);
    @(negedge clk);
    row_mask = 16'h0014;
    repeat (4) @(negedge clk);
    check("t6_skip_to_4", {binary, en}, {4'd4, 1'b1});
    repeat (ROW_T) @(negedge clk);
    check("t6_frame_done", {done, busy}, 2'b10);
    $display("txn live mask skip");

    // Continuous scan across rows 0 and 15.
    row_mask   = 16'h8001;
    continuous = 1'b1;
    pulse_start();
    for (int k = 0; k < 6 * ROW_T; k++) begin
      check("t3_row", binary, ((k / ROW_T) % 2 == 1) ? 15 : 0);
      check("t3_wrap", frame_wrap, (k > 0 && k % (2 * ROW_T) == 0) ? 1 : 0);
      check("t3_nodone", done, 0);
      @(negedge clk);
    end
    abort_scan();
    continuous = 1'b0;
    check("t3_stopped", {busy, done, frame_wrap}, 0);
    $display("txn continuous two-row scan");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
